// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg_if
// Description : Bundle of ID-side inputs, WB bypass inputs, EX control
//               inputs and EX-side outputs of the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // ID stage
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic [8:0]        id_ctrl;
    // WB write port (same signals that feed the register file)
    logic              wb_regwrite;
    logic [4:0]        wb_wn;
    logic [DATA_W-1:0] wb_wd;
    // Pipeline control
    logic              ex_flush;
    logic              ex_hold;
    // EX stage
    logic              hazard_stall;
    logic              ex_valid;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;
    logic [8:0]        ex_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    // Producer of ID/WB/control signals, consumer of EX outputs
    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_ctrl,
        output wb_regwrite, wb_wn, wb_wd, ex_flush, ex_hold,
        input  hazard_stall, ex_valid, ex_rs, ex_rt, ex_rd,
        input  ex_a, ex_b, ex_imm, ex_ctrl, bubble_cnt
    );

    // The pipeline register itself
    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_ctrl,
        input  wb_regwrite, wb_wn, wb_wd, ex_flush, ex_hold,
        output hazard_stall, ex_valid, ex_rs, ex_rt, ex_rd,
        output ex_a, ex_b, ex_imm, ex_ctrl, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with same-cycle WB bypass, load-use
//               hazard detection/bubble insertion, flush, hold and a
//               saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input wire                clk,
    input wire                rst_n,
    id_ex_stage_reg_if.slave  bus
);

    localparam int               c_memread_bit = 2;
    localparam logic [CNT_W-1:0] c_cnt_one     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

    logic              ex_valid_q,   ex_valid_d;
    logic [4:0]        ex_rs_q,      ex_rs_d;
    logic [4:0]        ex_rt_q,      ex_rt_d;
    logic [4:0]        ex_rd_q,      ex_rd_d;
    logic [DATA_W-1:0] ex_a_q,       ex_a_d;
    logic [DATA_W-1:0] ex_b_q,       ex_b_d;
    logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
    logic [8:0]        ex_ctrl_q,    ex_ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic [DATA_W-1:0] w_a_in;
    logic [DATA_W-1:0] w_b_in;
    logic              w_hazard;

    // Bypass the WB write into the operands; the register file returns the
    // pre-write value in the same cycle. Register 0 is hard-wired to zero.
    always_comb begin
        w_a_in = bus.id_rd1;
        w_b_in = bus.id_rd2;
        if (bus.wb_regwrite && (bus.wb_wn != 5'd0) && (bus.wb_wn == bus.id_rs)) begin
            w_a_in = bus.wb_wd;
        end
        if (bus.wb_regwrite && (bus.wb_wn != 5'd0) && (bus.wb_wn == bus.id_rt)) begin
            w_b_in = bus.wb_wd;
        end
    end

    // Load-use detection against the load currently in EX; rt is compared
    // even if the ID instruction does not read it (conservative).
    always_comb begin
        w_hazard = bus.id_valid && ex_valid_q && ex_ctrl_q[c_memread_bit] &&
                   (ex_rt_q != 5'd0) &&
                   ((ex_rt_q == bus.id_rs) || (ex_rt_q == bus.id_rt));
    end

    // Next-state selection: flush > hold > bubble > load.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_imm_d     = ex_imm_q;
        ex_ctrl_d    = ex_ctrl_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.ex_flush) begin
            // Squash only: data fields keep their old values.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = 9'd0;
        end else if (bus.ex_hold) begin
            // Everything frozen, including the counter.
        end else if (w_hazard) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = 9'd0;
            if (bubble_cnt_q != c_cnt_max) begin
                bubble_cnt_d = bubble_cnt_q + c_cnt_one;
            end
        end else begin
            ex_valid_d = bus.id_valid;
            ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : 9'd0;
            ex_rs_d    = bus.id_rs;
            ex_rt_d    = bus.id_rt;
            ex_rd_d    = bus.id_rd;
            ex_a_d     = w_a_in;
            ex_b_d     = w_b_in;
            ex_imm_d   = bus.id_imm;
        end
    end

    // EX-side state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= 5'd0;
            ex_rt_q      <= 5'd0;
            ex_rd_q      <= 5'd0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_imm_q     <= '0;
            ex_ctrl_q    <= 9'd0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_imm_q     <= ex_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.hazard_stall = w_hazard;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_a         = ex_a_q;
    assign bus.ex_b         = ex_b_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.bubble_cnt   = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Directed-vector bench for id_ex_stage_reg with a queue-based
//               scoreboard (counter width reduced to 2 for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
    localparam logic [8:0] c_lw  = 9'h017; // RegWrite|MemtoReg|MemRead|ALUSrc
    localparam logic [8:0] c_add = 9'h0A1; // RegWrite|RegDst|ALUOp=010

    logic clk;
    logic rst_n;

    id_ex_stage_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_stall;
        logic        stall;
        bit          chk_data;
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic [8:0]  ctrl;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Staged stimulus, applied to the interface at the next falling edge
    logic        s_rst_n, s_flush, s_hold, s_idv, s_we;
    logic [4:0]  s_rs, s_rt, s_rd, s_wn;
    logic [31:0] s_rd1, s_rd2, s_imm, s_wd;
    logic [8:0]  s_ctrl;

    task automatic chk(input string nm, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm,
                          input logic [8:0] ctrl);
        s_idv = v; s_rs = rs; s_rt = rt; s_rd = rd;
        s_rd1 = rd1; s_rd2 = rd2; s_imm = imm; s_ctrl = ctrl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] wn, input logic [31:0] wd);
        s_we = we; s_wn = wn; s_wd = wd;
    endtask

    // Apply staged inputs for one cycle and queue the expected response:
    // hazard_stall during the cycle, registers after the following edge.
    task automatic cyc(input string nm, input bit cs, input logic st, input bit cd,
                       input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [8:0] ctrl,
                       input logic [1:0] cnt);
        exp_t e;
        @(negedge clk);
        rst_n           = s_rst_n;
        bus.ex_flush    = s_flush;
        bus.ex_hold     = s_hold;
        bus.id_valid    = s_idv;
        bus.id_rs       = s_rs;
        bus.id_rt       = s_rt;
        bus.id_rd       = s_rd;
        bus.id_rd1      = s_rd1;
        bus.id_rd2      = s_rd2;
        bus.id_imm      = s_imm;
        bus.id_ctrl     = s_ctrl;
        bus.wb_regwrite = s_we;
        bus.wb_wn       = s_wn;
        bus.wb_wd       = s_wd;
        e.name = nm; e.chk_stall = cs; e.stall = st; e.chk_data = cd; e.valid = v;
        e.rs = rs; e.rt = rt; e.rd = rd; e.a = a; e.b = b; e.imm = imm;
        e.ctrl = ctrl; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per presented cycle and compares
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk_stall) chk(e.name, "hazard_stall", 32'(bus.hazard_stall), 32'(e.stall));
                @(posedge clk);
                #1;
                chk(e.name, "ex_valid",   32'(bus.ex_valid),   32'(e.valid));
                chk(e.name, "ex_ctrl",    32'(bus.ex_ctrl),    32'(e.ctrl));
                chk(e.name, "bubble_cnt", 32'(bus.bubble_cnt), 32'(e.cnt));
                if (e.chk_data) begin
                    chk(e.name, "ex_rs",  32'(bus.ex_rs), 32'(e.rs));
                    chk(e.name, "ex_rt",  32'(bus.ex_rt), 32'(e.rt));
                    chk(e.name, "ex_rd",  32'(bus.ex_rd), 32'(e.rd));
                    chk(e.name, "ex_a",   bus.ex_a,   e.a);
                    chk(e.name, "ex_b",   bus.ex_b,   e.b);
                    chk(e.name, "ex_imm", bus.ex_imm, e.imm);
                end
            end
        end
    end

    // Driver: directed vectors with hand-computed expectations
    initial begin : driver
        rst_n = 1'b0;
        bus.ex_flush = 1'b0; bus.ex_hold = 1'b0; bus.id_valid = 1'b0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_rd1 = '0; bus.id_rd2 = '0; bus.id_imm = '0; bus.id_ctrl = '0;
        bus.wb_regwrite = 1'b0; bus.wb_wn = '0; bus.wb_wd = '0;
        s_rst_n = 1'b0; s_flush = 1'b0; s_hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);

        cyc("reset", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        s_rst_n = 1'b1;
        set_id(1, 5, 6, 7, 32'h1, 32'h2, 32'h10, c_add);
        set_wb(1, 5, 32'hDEADBEEF);
        cyc("bypass_a", 1, 0, 1, 1, 5, 6, 7, 32'hDEADBEEF, 32'h2, 32'h10, c_add, 0);

        set_id(1, 0, 0, 3, 32'h0, 32'h0, 32'h0, c_add);
        set_wb(1, 0, 32'hFFFF);
        cyc("r0_rule", 1, 0, 1, 1, 0, 0, 3, 32'h0, 32'h0, 32'h0, c_add, 0);

        set_id(1, 6, 6, 2, 32'h11, 32'h22, 32'h5, c_add);
        set_wb(1, 6, 32'h66);
        cyc("bypass_ab", 1, 0, 1, 1, 6, 6, 2, 32'h66, 32'h66, 32'h5, c_add, 0);

        set_id(1, 6, 7, 2, 32'h11, 32'h22, 32'h5, c_add);
        set_wb(0, 6, 32'h66);
        cyc("no_wb_write", 1, 0, 1, 1, 6, 7, 2, 32'h11, 32'h22, 32'h5, c_add, 0);

        set_wb(0, 0, 0);
        set_id(1, 2, 8, 0, 32'h100, 32'h200, 32'h4, c_lw);
        cyc("load_lw", 1, 0, 1, 1, 2, 8, 0, 32'h100, 32'h200, 32'h4, c_lw, 0);

        set_id(1, 8, 3, 9, 32'h8, 32'h3, 32'h0, c_add);
        cyc("load_use_bubble", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("after_bubble", 1, 0, 1, 1, 8, 3, 9, 32'h8, 32'h3, 32'h0, c_add, 1);

        set_id(1, 1, 4, 0, 32'h40, 32'h0, 32'h8, c_lw);
        cyc("load_lw2", 1, 0, 1, 1, 1, 4, 0, 32'h40, 32'h0, 32'h8, c_lw, 1);

        set_id(1, 3, 4, 9, 32'h30, 32'h40, 32'h0, c_add);
        s_flush = 1'b1;
        cyc("flush_vs_hazard", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        s_flush = 1'b0;
        cyc("after_flush", 1, 0, 1, 1, 3, 4, 9, 32'h30, 32'h40, 32'h0, c_add, 1);

        s_hold = 1'b1;
        set_id(1, 10, 11, 12, 32'hA, 32'hB, 32'hC, c_lw);
        cyc("hold1", 1, 0, 1, 1, 3, 4, 9, 32'h30, 32'h40, 32'h0, c_add, 1);
        set_id(1, 13, 14, 15, 32'h1A, 32'h1B, 32'h1C, c_add);
        cyc("hold2", 1, 0, 1, 1, 3, 4, 9, 32'h30, 32'h40, 32'h0, c_add, 1);
        set_id(0, 16, 17, 18, 32'h2A, 32'h2B, 32'h2C, 9'h1FF);
        cyc("hold3", 1, 0, 1, 1, 3, 4, 9, 32'h30, 32'h40, 32'h0, c_add, 1);
        s_hold = 1'b0;
        set_id(1, 10, 11, 12, 32'hAA, 32'hBB, 32'hCC, c_lw);
        cyc("hold_release", 1, 0, 1, 1, 10, 11, 12, 32'hAA, 32'hBB, 32'hCC, c_lw, 1);

        s_hold = 1'b1;
        set_id(1, 11, 0, 1, 32'h1, 32'h2, 32'h3, c_add);
        cyc("hold_over_hazard", 1, 1, 1, 1, 10, 11, 12, 32'hAA, 32'hBB, 32'hCC, c_lw, 1);
        s_hold = 1'b0;
        cyc("hazard_after_hold", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

        set_id(1, 0, 5, 0, 32'h0, 32'h55, 32'h20, c_lw);
        cyc("load_lw3", 1, 0, 1, 1, 0, 5, 0, 32'h0, 32'h55, 32'h20, c_lw, 2);

        s_rst_n = 1'b0;
        set_id(1, 5, 6, 7, 32'h50, 32'h60, 32'h0, c_add);
        cyc("reset_mid_op", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_rst_n = 1'b1;
        cyc("after_reset", 1, 0, 1, 1, 5, 6, 7, 32'h50, 32'h60, 32'h0, c_add, 0);

        set_id(1, 8, 8, 0, 32'h80, 32'h88, 32'h0, c_lw);
        cyc("sat_load0", 1, 0, 1, 1, 8, 8, 0, 32'h80, 32'h88, 32'h0, c_lw, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc("sat_bubble", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i >= 3) ? 2'd3 : 2'(i));
            cyc("sat_load", 1, 0, 1, 1, 8, 8, 0, 32'h80, 32'h88, 32'h0, c_lw,
                (i >= 3) ? 2'd3 : 2'(i));
        end

        set_id(0, 1, 2, 3, 32'h5, 32'h6, 32'h7, 9'h1FF);
        cyc("invalid_id", 1, 0, 1, 0, 1, 2, 3, 32'h5, 32'h6, 32'h7, 9'h000, 3);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
